mem_init_sequencer: RTL and testbench
=====================================

// Module: mem_init_sequencer
// PURPOSE
//  Boot sequencer for the single-cycle MIPS system. Owns the data port (port 1) of the dual-port
//  instruction/data RAM during initialisation, zero-fills a configurable word range, then releases
//  the CPU's active-low reset.
//  Sits between MIPS_cpu (MemWrite/MemAddr/MemWData) and the RAM port-1 inputs. Port 0 (fetch) is untouched.
// PARAMETERS
//  DWIDTH       32   data width of RAM port 1
//  AWIDTH       12   word-address width of RAM port 1
//  CLR_BASE     0    first word index zero-filled (AWIDTH bits)
//  CLR_WORDS    1024 number of words zero-filled; 0 skips CLEAR
//  HOLD_CYCLES  4    cycles spent in HOLD before CLEAR; values below 1 behave as 1
// PORTS
//  clk        in   1       system clock; all state changes on posedge
//  reset      in   1       asynchronous, active-high reset
//  restart    in   1       synchronous request; high at a posedge re-enters HOLD from any state
//  cpu_we     in   1       CPU data write enable (active high)
//  cpu_addr   in   AWIDTH  CPU data word address
//  cpu_wdata  in   DWIDTH  CPU write data
//  mem_we     out  1       RAM port-1 write enable
//  mem_addr   out  AWIDTH  RAM port-1 word address
//  mem_wdata  out  DWIDTH  RAM port-1 write data
//  cpu_rst_n  out  1       CPU reset, active low, registered
//  busy       out  1       1 in every state except RUN
//  done       out  1       one-cycle pulse in the first RUN cycle
// BEHAVIOUR
//  States: HOLD -> CLEAR -> RELEASE -> RUN. Counters: hold_cnt, clr_idx.
//  reset=1 (async):
//   - state=HOLD; hold_cnt=0, clr_idx=0.
//   - Outputs: cpu_rst_n=0, busy=1, done=0, mem_we=0, mem_addr=0, mem_wdata=0.
//  HOLD:
//   - mem_we=0; hold_cnt increments each posedge.
//   - After max(HOLD_CYCLES,1) posedges -> CLEAR, or -> RELEASE if CLR_WORDS==0.
//  CLEAR, one word per cycle:
//   - mem_we=1, mem_addr=(CLR_BASE+clr_idx) mod 2^AWIDTH, mem_wdata=0.
//   - clr_idx increments each posedge.
//   - After the write with clr_idx==CLR_WORDS-1 -> RELEASE. Exactly CLR_WORDS writes.
//   - Address wrap past 2^AWIDTH-1 to 0 is legal and required.
//  RELEASE (one cycle):
//   - mem_we=0, cpu_rst_n still 0. Guarantees the last clear write lands before the CPU fetches.
//   - Next posedge -> RUN.
//  RUN:
//   - cpu_rst_n=1 (registered, rises at the RELEASE->RUN edge).
//   - Port 1 is a combinational pass-through (mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata).
//     Zero added latency: the CPU is single-cycle.
//   - done=1 for the first RUN cycle only; busy=0.
//  In every non-RUN state, cpu_we/addr/wdata are ignored and never reach the RAM.
//  restart sampled 1 at any posedge, in any state:
//   - next state=HOLD; counters cleared; cpu_rst_n=0 from that edge.
//   - A CLEAR interrupted this way restarts from clr_idx=0.
//   - restart held high keeps the block in HOLD.
//  restart and the final CLEAR/HOLD edge coincide: restart wins.
//  reset mid-CLEAR: mem_we drops to 0 asynchronously; no partial word is written after assertion.
//  Latency, from reset deassert to cpu_rst_n=1: max(HOLD_CYCLES,1) + CLR_WORDS + 1 posedges.
// TESTING (HOLD_CYCLES=4, CLR_BASE=16, CLR_WORDS=8 unless noted)
//  1. Preload words 15..24 with 0xFFFFFFFF; release reset
//     -> words 16..23 read 0; words 15 and 24 unchanged; cpu_rst_n rises at posedge 13; done pulses once.
//  2. In RUN, cpu_we=1, addr=5, wdata=0xDEADBEEF
//     -> same-cycle mem_we=1, mem_addr=5; word 5 holds 0xDEADBEEF. In CLEAR the same stimulus leaves word 5 unchanged.
//  3. CLR_BASE=4094, CLR_WORDS=4
//     -> writes to 4094, 4095, 0, 1 in order; word 2 unchanged.
//  4. Pulse restart for 1 cycle during the 3rd CLEAR write
//     -> busy stays 1; cpu_rst_n stays 0; sweep restarts at 16; 8 full writes follow; release at +13 edges.
//  5. Assert reset asynchronously mid-cycle in CLEAR
//     -> mem_we, cpu_rst_n=0 immediately, without waiting for clk; sequence replays from HOLD after deassert.
//  6. CLR_WORDS=0, HOLD_CYCLES=0
//     -> no mem_we pulses; cpu_rst_n rises at posedge 2 after reset deassert.

Source files
------------

// File: rtl/mem_init_sequencer.sv
// Boot sequencer for the single-cycle MIPS system: owns RAM port 1 during init,
// zero-fills a word range, then releases the CPU reset and passes CPU traffic through.
module mem_init_sequencer #(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned AWIDTH      = 12,
    parameter int unsigned CLR_BASE    = 0,
    parameter int unsigned CLR_WORDS   = 1024,
    parameter int          HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done
);

    localparam int          HOLD_EFF_S = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int unsigned HOLD_EFF   = HOLD_EFF_S;
    localparam int unsigned HCW        = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
    localparam int unsigned CW         = (CLR_WORDS > 1) ? $clog2(CLR_WORDS) : 1;
    localparam int unsigned CLR_LAST_I = (CLR_WORDS > 0) ? CLR_WORDS - 1 : 0;
    localparam logic [HCW-1:0]    HOLD_LAST  = HCW'(HOLD_EFF - 1);
    localparam logic [CW-1:0]     CLR_LAST   = CW'(CLR_LAST_I);
    localparam logic [AWIDTH-1:0] BASE       = AWIDTH'(CLR_BASE);
    localparam bit                SKIP_CLEAR = (CLR_WORDS == 0);

    typedef enum logic [1:0] {
        S_HOLD,
        S_CLEAR,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t            state, state_next;
    logic [HCW-1:0]    hold_cnt, hold_cnt_next;
    logic [CW-1:0]     clr_idx, clr_idx_next;
    logic [AWIDTH-1:0] clr_addr;

    // Sweep address wraps naturally modulo 2^AWIDTH.
    assign clr_addr = BASE + AWIDTH'(clr_idx);
    assign busy     = (state != S_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_HOLD;
            hold_cnt  <= '0;
            clr_idx   <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            hold_cnt  <= hold_cnt_next;
            clr_idx   <= clr_idx_next;
            cpu_rst_n <= (state_next == S_RUN);
            done      <= (state_next == S_RUN) && (state != S_RUN);
        end
    end

    // Port-1 mux is combinational so reset drops mem_we without waiting for clk.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        clr_idx_next  = clr_idx;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;

        case (state)
            S_HOLD: begin
                hold_cnt_next = hold_cnt + HCW'(1);
                if (hold_cnt == HOLD_LAST) begin
                    hold_cnt_next = '0;
                    state_next    = SKIP_CLEAR ? S_RELEASE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                mem_we       = 1'b1;
                mem_addr     = clr_addr;
                clr_idx_next = clr_idx + CW'(1);
                if (clr_idx == CLR_LAST) begin
                    clr_idx_next = '0;
                    state_next   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            default: begin
                state_next = S_HOLD;
            end
        endcase

        // restart overrides any transition decided above.
        if (restart) begin
            state_next    = S_HOLD;
            hold_cnt_next = '0;
            clr_idx_next  = '0;
        end
    end

endmodule

// File: tb/tb_mem_init_sequencer.sv
// Directed bench for mem_init_sequencer: a RAM model plus write scoreboards for
// the main, address-wrap and no-clear configurations.
module tb_mem_init_sequencer;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        rst_aux;
    logic        restart;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;

    logic        w_we, w_rst_n, w_busy, w_done;
    logic [11:0] w_addr;
    logic [31:0] w_wdata;
    logic        z_we, z_rst_n, z_busy, z_done;
    logic [11:0] z_addr;
    logic [31:0] z_wdata;

    logic        pre_we;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;
    logic [31:0] ram [0:4095];

    wr_t sb[$];
    wr_t sb_w[$];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int w_cnt = 0;
    int z_we_cnt = 0;
    int z_done_cnt = 0;
    int w_done_cnt = 0;
    int edge_n = 0;
    int w_rise = 0;
    int z_rise = 0;

    mem_init_sequencer #(.DWIDTH(32), .AWIDTH(12), .CLR_BASE(16), .CLR_WORDS(8), .HOLD_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done)
    );

    mem_init_sequencer #(.DWIDTH(32), .AWIDTH(12), .CLR_BASE(4094), .CLR_WORDS(4), .HOLD_CYCLES(4)) dut_wrap (
        .clk(clk), .reset(rst_aux), .restart(1'b0),
        .cpu_we(1'b0), .cpu_addr(12'd0), .cpu_wdata(32'd0),
        .mem_we(w_we), .mem_addr(w_addr), .mem_wdata(w_wdata),
        .cpu_rst_n(w_rst_n), .busy(w_busy), .done(w_done)
    );

    mem_init_sequencer #(.DWIDTH(32), .AWIDTH(12), .CLR_BASE(16), .CLR_WORDS(0), .HOLD_CYCLES(0)) dut_zero (
        .clk(clk), .reset(rst_aux), .restart(1'b0),
        .cpu_we(1'b0), .cpu_addr(12'd0), .cpu_wdata(32'd0),
        .mem_we(z_we), .mem_addr(z_addr), .mem_wdata(z_wdata),
        .cpu_rst_n(z_rst_n), .busy(z_busy), .done(z_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // RAM port-1 model; bench preloads only when the DUT is not writing.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else if (pre_we) ram[pre_addr] <= pre_data;
    end

    always @(posedge clk) begin
        if (rst_aux) edge_n <= 0;
        else edge_n <= edge_n + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Main-instance write monitor: every port-1 write must match the next expected entry.
    always @(negedge clk) begin
        wr_t e;
        if (!reset && mem_we) begin
            check("main_write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("main_write_addr", 64'(mem_addr), 64'(e.addr));
                check("main_write_data", 64'(mem_wdata), 64'(e.data));
            end
        end
        if (!reset && done) done_cnt++;
    end

    always @(negedge clk) begin
        wr_t e;
        if (!rst_aux && w_we) begin
            w_cnt++;
            check("wrap_write_expected", 64'(sb_w.size() != 0), 64'd1);
            if (sb_w.size() != 0) begin
                e = sb_w.pop_front();
                check("wrap_write_addr", 64'(w_addr), 64'(e.addr));
                check("wrap_write_data", 64'(w_wdata), 64'(e.data));
            end
        end
        if (!rst_aux && z_we) z_we_cnt++;
        if (!rst_aux && z_done) z_done_cnt++;
        if (!rst_aux && w_done) w_done_cnt++;
        if (!rst_aux && z_rst_n && z_rise == 0) z_rise = edge_n;
        if (!rst_aux && w_rst_n && w_rise == 0) w_rise = edge_n;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic push_sweep();
        for (int i = 16; i < 24; i++) sb.push_back('{addr: 12'(i), data: 32'd0});
    endtask

    task automatic wait_release(input string tag, input int exp_edges);
        int n = 0;
        while (!cpu_rst_n && n < 40) begin
            step();
            n++;
        end
        check(tag, 64'(n), 64'(exp_edges));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        rst_aux   = 1'b1;
        restart   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;

        step();
        check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);

        // Boot sweep over 16..23 with guard words preloaded around it.
        for (int i = 15; i <= 24; i++) preload(12'(i), 32'hFFFF_FFFF);
        push_sweep();
        sb_w.push_back('{addr: 12'd4094, data: 32'd0});
        sb_w.push_back('{addr: 12'd4095, data: 32'd0});
        sb_w.push_back('{addr: 12'd0, data: 32'd0});
        sb_w.push_back('{addr: 12'd1, data: 32'd0});
        reset   = 1'b0;
        rst_aux = 1'b0;
        wait_release("t1_release_edges", 13);
        step();
        check("t1_done_one_cycle", 64'(done), 64'd0);
        check("t1_guard_15", 64'(ram[15]), 64'hFFFF_FFFF);
        check("t1_guard_24", 64'(ram[24]), 64'hFFFF_FFFF);
        for (int i = 16; i < 24; i++) check("t1_cleared_word", 64'(ram[i]), 64'd0);

        // Zero-latency CPU pass-through in RUN.
        cpu_we    = 1'b1;
        cpu_addr  = 12'd5;
        cpu_wdata = 32'hDEAD_BEEF;
        sb.push_back('{addr: 12'd5, data: 32'hDEAD_BEEF});
        #1;
        check("t2_pass_we", 64'(mem_we), 64'd1);
        check("t2_pass_addr", 64'(mem_addr), 64'd5);
        check("t2_pass_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        step();
        cpu_we = 1'b0;
        check("t2_word5", 64'(ram[5]), 64'hDEAD_BEEF);

        // Restart during the third clear write; sweep must begin again at 16.
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("t4_restart_busy", 64'(busy), 64'd1);
        check("t4_restart_rst_n", 64'(cpu_rst_n), 64'd0);
        for (int i = 16; i < 19; i++) sb.push_back('{addr: 12'(i), data: 32'd0});
        repeat (6) step();
        check("t4_third_write_we", 64'(mem_we), 64'd1);
        check("t4_third_write_addr", 64'(mem_addr), 64'd18);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("t4_after_busy", 64'(busy), 64'd1);
        check("t4_after_rst_n", 64'(cpu_rst_n), 64'd0);
        check("t4_after_we", 64'(mem_we), 64'd0);
        push_sweep();
        repeat (5) step();
        cpu_we    = 1'b1;
        cpu_addr  = 12'd5;
        cpu_wdata = 32'h1234_5678;
        #1;
        check("t2_clear_addr", 64'(mem_addr), 64'd17);
        check("t2_clear_wdata", 64'(mem_wdata), 64'd0);
        step();
        cpu_we = 1'b0;
        wait_release("t4_release_edges", 7);
        step();
        check("t2_clear_ignored", 64'(ram[5]), 64'hDEAD_BEEF);

        // Async reset in the middle of the second clear write.
        preload(12'd17, 32'hA5A5_A5A5);
        restart = 1'b1;
        step();
        restart = 1'b0;
        sb.push_back('{addr: 12'd16, data: 32'd0});
        repeat (5) step();
        reset = 1'b1;
        #1;
        check("t5_async_we", 64'(mem_we), 64'd0);
        check("t5_async_rst_n", 64'(cpu_rst_n), 64'd0);
        check("t5_async_addr", 64'(mem_addr), 64'd0);
        step();
        step();
        check("t5_no_partial", 64'(ram[17]), 64'hA5A5_A5A5);
        push_sweep();
        reset = 1'b0;
        wait_release("t5_release_edges", 13);
        check("t5_replayed", 64'(ram[17]), 64'd0);

        // restart held high keeps the block parked in HOLD.
        restart = 1'b1;
        repeat (10) step();
        check("held_busy", 64'(busy), 64'd1);
        check("held_rst_n", 64'(cpu_rst_n), 64'd0);
        check("held_we", 64'(mem_we), 64'd0);
        restart = 1'b0;
        push_sweep();
        wait_release("held_release_edges", 13);
        step();

        check("main_sb_drained", 64'(sb.size()), 64'd0);
        check("main_done_pulses", 64'(done_cnt), 64'd4);
        check("wrap_sb_drained", 64'(sb_w.size()), 64'd0);
        check("wrap_write_count", 64'(w_cnt), 64'd4);
        check("wrap_release_edge", 64'(w_rise), 64'd9);
        check("wrap_busy", 64'(w_busy), 64'd0);
        check("wrap_done_pulses", 64'(w_done_cnt), 64'd1);
        check("zero_no_writes", 64'(z_we_cnt), 64'd0);
        check("zero_release_edge", 64'(z_rise), 64'd2);
        check("zero_busy", 64'(z_busy), 64'd0);
        check("zero_done_pulses", 64'(z_done_cnt), 64'd1);
        check("zero_idle_port", 64'({z_addr, z_wdata}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
